// File: rtl/zipdma_traffic_gen.sv
// Wishbone pipelined burst generator: LFSR write data, LFSR-checked read data; first request one cycle after i_start.
// Backpressure: i_wb_stall holds addr/data/sel; acks may lag indefinitely up to TIMEOUT idle cycles, then the burst aborts.
module zipdma_traffic_gen #(
    parameter  int ADDRESS_WIDTH = 30,
    parameter  int BUS_WIDTH     = 64,
    parameter  int TIMEOUT       = 1023,
    localparam int DW            = BUS_WIDTH,
    localparam int BW            = DW / 8,
    localparam int AW            = ADDRESS_WIDTH - $clog2(BW)
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_start,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [11:0]   i_len,
    input  logic [31:0]   i_seed,
    input  logic [BW-1:0] i_sel,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_miscmp,
    output logic [11:0]   o_beats,
    output logic          o_wb_cyc,
    output logic          o_wb_stb,
    output logic          o_wb_we,
    output logic [AW-1:0] o_wb_addr,
    output logic [DW-1:0] o_wb_data,
    output logic [BW-1:0] o_wb_sel,
    input  logic          i_wb_stall,
    input  logic          i_wb_ack,
    input  logic          i_wb_err,
    input  logic [DW-1:0] i_wb_data
);
    localparam int TMW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_done;
    logic            r_done;
    logic            r_we;
    logic [BW-1:0]   r_sel;
    logic [11:0]     r_len;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_iss_lfsr;
    logic [DW-1:0]   r_chk_lfsr;
    logic [11:0]     r_issued;
    logic [11:0]     r_beats;
    logic [TMW-1:0]  r_tmo;
    logic            r_err;
    logic            r_miscmp;

    logic            w_cyc;
    logic            w_accept;
    logic            w_ack;
    logic            w_abort;
    logic            w_last_issue;
    logic            w_last_ack;
    logic            w_miscmp;

    function automatic logic [DW-1:0] f_step(input logic [DW-1:0] s);
        return {s[DW-2:0], s[DW-1] ^ s[DW-2]};
    endfunction

    assign w_cyc        = (r_state != S_IDLE);
    assign w_accept     = (r_state == S_REQ) && !i_wb_stall;
    // An error in the same cycle as an ack swallows the ack.
    assign w_ack        = w_cyc && i_wb_ack && !i_wb_err;
    assign w_abort      = w_cyc && (i_wb_err || (!i_wb_ack && (r_tmo == TMW'(TIMEOUT - 1))));
    assign w_last_issue = w_accept && ((r_issued + 12'd1) == r_len);
    assign w_last_ack   = w_ack && ((r_beats + 12'd1) == r_len);

    always_comb begin
        w_miscmp = 1'b0;
        for (int b = 0; b < BW; b++) begin
            if (r_sel[b] && (i_wb_data[8*b +: 8] != r_chk_lfsr[8*b +: 8])) begin
                w_miscmp = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_len != 12'd0) begin
                        w_next = S_REQ;
                    end else begin
                        w_done = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (w_abort || w_last_ack) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if (w_last_issue) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_abort || w_last_ack) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_done     <= 1'b0;
            r_we       <= 1'b0;
            r_sel      <= '0;
            r_len      <= '0;
            r_addr     <= '0;
            r_iss_lfsr <= '0;
            r_chk_lfsr <= '0;
            r_issued   <= '0;
            r_beats    <= '0;
            r_tmo      <= '0;
            r_err      <= 1'b0;
            r_miscmp   <= 1'b0;
        end else begin
            r_done <= w_done;
            if (r_state == S_IDLE) begin
                if (i_start) begin
                    r_err    <= 1'b0;
                    r_miscmp <= 1'b0;
                    r_beats  <= '0;
                    if (i_len != 12'd0) begin
                        r_we       <= i_we;
                        r_sel      <= i_sel;
                        r_len      <= i_len;
                        r_addr     <= i_addr;
                        r_iss_lfsr <= DW'(i_seed);
                        r_chk_lfsr <= DW'(i_seed);
                        r_issued   <= '0;
                        r_tmo      <= '0;
                    end
                end
            end else begin
                if (w_accept) begin
                    r_addr     <= r_addr + AW'(1);
                    r_iss_lfsr <= f_step(r_iss_lfsr);
                    r_issued   <= r_issued + 12'd1;
                end
                if (i_wb_ack) begin
                    r_tmo <= '0;
                end else begin
                    r_tmo <= r_tmo + TMW'(1);
                end
                if (w_abort) begin
                    r_err <= 1'b1;
                end else if (w_ack) begin
                    r_beats <= r_beats + 12'd1;
                    if (!r_we) begin
                        r_chk_lfsr <= f_step(r_chk_lfsr);
                        if (w_miscmp) begin
                            r_miscmp <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign o_busy    = w_cyc;
    assign o_done    = r_done;
    assign o_err     = r_err;
    assign o_miscmp  = r_miscmp;
    assign o_beats   = r_beats;
    assign o_wb_cyc  = w_cyc;
    assign o_wb_stb  = (r_state == S_REQ);
    assign o_wb_we   = r_we;
    assign o_wb_addr = r_addr;
    assign o_wb_data = r_we ? r_iss_lfsr : '0;
    assign o_wb_sel  = r_sel;
endmodule

// File: tb/tb_zipdma_traffic_gen.sv
// Directed bench for zipdma_traffic_gen: a pipelined Wishbone slave model plus a request scoreboard.
module tb_zipdma_traffic_gen;
    localparam int AW  = 27;
    localparam int DW  = 64;
    localparam int BW  = 8;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          i_reset_n, i_start, i_we;
    logic [AW-1:0] i_addr;
    logic [11:0]   i_len;
    logic [31:0]   i_seed;
    logic [BW-1:0] i_sel;
    logic          o_busy, o_done, o_err, o_miscmp;
    logic [11:0]   o_beats;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic [DW-1:0] o_wb_data;
    logic [BW-1:0] o_wb_sel;
    logic          i_wb_stall, i_wb_ack, i_wb_err;
    logic [DW-1:0] i_wb_data;

    always #5 clk = ~clk;

    zipdma_traffic_gen #(.ADDRESS_WIDTH(30), .BUS_WIDTH(64), .TIMEOUT(TMO)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_we(i_we),
        .i_addr(i_addr), .i_len(i_len), .i_seed(i_seed), .i_sel(i_sel),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_miscmp(o_miscmp),
        .o_beats(o_beats), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] pend[$];
    logic [DW-1:0] slave_lfsr;
    logic [BW-1:0] exp_sel;

    int stall_beat, stall_left, err_ack, corrupt_beat;
    bit no_ack, got_done;
    int issued, acks, cyc_cycles, max_out, err_cyc, done_cyc;

    function automatic logic [DW-1:0] step(input logic [DW-1:0] s);
        return {s[DW-2:0], s[DW-1] ^ s[DW-2]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic knobs(input int sb, input int sc, input int ea, input int cb, input bit na);
        stall_beat = sb; stall_left = sc; err_ack = ea; corrupt_beat = cb; no_ack = na;
    endtask

    // Called at a negedge; pushes the expected request stream, pulses i_start for one cycle.
    task automatic start_cmd(input bit we, input logic [AW-1:0] addr, input logic [11:0] len,
                             input logic [31:0] seed, input logic [BW-1:0] sel);
        logic [AW-1:0] a;
        logic [DW-1:0] s;
        exp_addr.delete(); exp_data.delete(); pend.delete();
        a = addr;
        s = DW'(seed);
        for (int k = 0; k < int'(len); k++) begin
            exp_addr.push_back(a);
            exp_data.push_back(we ? s : '0);
            a = a + AW'(1);
            s = step(s);
        end
        slave_lfsr = DW'(seed);
        exp_sel = sel;
        i_we = we; i_addr = addr; i_len = len; i_seed = seed; i_sel = sel;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic run(input int budget);
        got_done = 0; issued = 0; acks = 0; cyc_cycles = 0; max_out = 0;
        err_cyc = -1; done_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            if (o_done) begin
                got_done = 1;
                done_cyc = c;
                break;
            end
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_data = '0;
            i_wb_stall = o_wb_stb && (issued == stall_beat) && (stall_left > 0);
            if (!no_ack && pend.size() > 0) begin
                i_wb_ack = 1'b1;
                acks++;
                if (acks == err_ack) begin
                    i_wb_err = 1'b1;
                    err_cyc = c;
                end
                i_wb_data = pend.pop_front();
            end
            if (i_wb_stall) begin
                stall_left--;
                if (exp_addr.size() > 0) begin
                    chk("stall_addr_hold", o_wb_addr, exp_addr[0]);
                    chk("stall_data_hold", o_wb_data, exp_data[0]);
                end
            end else if (o_wb_stb) begin
                if (exp_addr.size() > 0) begin
                    chk("req_addr", o_wb_addr, exp_addr.pop_front());
                    chk("req_data", o_wb_data, exp_data.pop_front());
                    chk("req_sel", o_wb_sel, exp_sel);
                end
                pend.push_back(slave_lfsr ^ ((issued == corrupt_beat) ? 64'h1 : 64'h0));
                slave_lfsr = step(slave_lfsr);
                issued++;
            end
            if (issued - acks > max_out) max_out = issued - acks;
            if (o_wb_cyc) cyc_cycles++;
            @(negedge clk);
        end
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_data = '0;
    endtask

    task automatic post(input int beats, input bit err, input bit mis, input int n_iss, input int len);
        chk("done_seen", got_done, 1);
        chk("cyc_low_at_done", o_wb_cyc, 0);
        chk("beats", o_beats, beats);
        chk("err", o_err, err);
        chk("miscmp", o_miscmp, mis);
        chk("issued", issued, n_iss);
        chk("outstanding_bound", max_out <= len, 1);
        @(negedge clk);
        chk("done_single_pulse", o_done, 0);
        chk("busy_after_done", o_busy, 0);
    endtask

    initial begin
        i_reset_n = 1'b0; i_start = 1'b0; i_we = 1'b0; i_addr = '0; i_len = '0;
        i_seed = '0; i_sel = '0; i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        i_wb_data = '0;
        knobs(-1, 0, -1, -1, 0);
        #12;
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_stb", o_wb_stb, 0);
        chk("rst_addr", o_wb_addr, 0);
        chk("rst_data", o_wb_data, 0);
        chk("rst_beats", o_beats, 0);
        @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);

        // Write burst, zero-stall slave
        knobs(-1, 0, -1, -1, 0);
        start_cmd(1'b1, AW'('h10), 12'd4, 32'd1, 8'hFF);
        run(60);
        post(4, 0, 0, 4, 4);

        // Read burst with clean stream, then byte 0 of beat 3 corrupted
        knobs(-1, 0, -1, -1, 0);
        start_cmd(1'b0, AW'('h200), 12'd8, 32'd1, 8'hFF);
        run(60);
        post(8, 0, 0, 8, 8);
        knobs(-1, 0, -1, 3, 0);
        start_cmd(1'b0, AW'('h200), 12'd8, 32'd1, 8'hFF);
        run(60);
        post(8, 0, 1, 8, 8);
        // Same corruption, but byte 0 masked off by sel
        knobs(-1, 0, -1, 3, 0);
        start_cmd(1'b0, AW'('h200), 12'd8, 32'd1, 8'hFE);
        run(60);
        post(8, 0, 0, 8, 8);

        // Stall for 3 cycles on request 2
        knobs(2, 3, -1, -1, 0);
        start_cmd(1'b1, AW'('h40), 12'd4, 32'h5A5A, 8'h0F);
        run(60);
        chk("stall_consumed", stall_left, 0);
        post(4, 0, 0, 4, 4);

        // Bus error on ack 2 of 5 (ack asserted with err: not counted)
        knobs(-1, 0, 2, -1, 0);
        start_cmd(1'b1, AW'('h80), 12'd5, 32'd7, 8'hFF);
        run(60);
        chk("err_to_done_cycles", done_cyc - err_cyc, 1);
        post(1, 1, 0, 3, 5);

        // Timeout: slave never acks
        knobs(-1, 0, -1, -1, 1);
        start_cmd(1'b1, AW'('h90), 12'd4, 32'd1, 8'hFF);
        run(100);
        chk("timeout_cyc_cycles", cyc_cycles, TMO);
        post(0, 1, 0, 4, 4);

        // Zero-length command: done pulse, no bus cycle, status cleared
        knobs(-1, 0, -1, -1, 0);
        start_cmd(1'b1, AW'('h10), 12'd0, 32'd1, 8'hFF);
        run(10);
        chk("len0_no_cyc", cyc_cycles, 0);
        post(0, 0, 0, 0, 0);

        // Address wrap at the top of the word space
        knobs(-1, 0, -1, -1, 0);
        start_cmd(1'b1, {AW{1'b1}}, 12'd2, 32'd3, 8'hFF);
        run(30);
        post(2, 0, 0, 2, 2);

        // Asynchronous reset mid-burst
        knobs(-1, 0, -1, -1, 0);
        start_cmd(1'b1, AW'('h55), 12'd8, 32'd3, 8'hFF);
        run(3);
        chk("pre_reset_no_done", got_done, 0);
        chk("pre_reset_cyc", o_wb_cyc, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("arst_cyc", o_wb_cyc, 0);
        chk("arst_stb", o_wb_stb, 0);
        chk("arst_we", o_wb_we, 0);
        chk("arst_addr", o_wb_addr, 0);
        chk("arst_data", o_wb_data, 0);
        chk("arst_sel", o_wb_sel, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_flags", {o_done, o_err, o_miscmp}, 0);
        chk("arst_beats", o_beats, 0);
        @(negedge clk);
        i_reset_n = 1'b1;
        pend.delete();
        run(5);
        chk("post_reset_no_done", got_done, 0);
        chk("post_reset_no_cyc", cyc_cycles, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
